// File: rtl/pat_pkg.sv
// Shared geometry and types for the pattern-buffer scheduler.
//
// Purpose : ring geometry of the pattern buffers (buffer index width, field
//           index width, field data width), derived counts, the memory
//           address layout {buffer, field}, and the round-robin owner type
//           used by the shared memory port arbiter.
// Ports   : none (package).
package pat_pkg;

  localparam int BUFP_W   = 3;
  localparam int FIELDP_W = 5;
  localparam int BUF_W    = 8;

  localparam int NBUF   = 1 << BUFP_W;
  localparam int NFIELD = 1 << FIELDP_W;
  localparam int ADDR_W = BUFP_W + FIELDP_W;

  // Memory address: buffer index in the upper bits, field index below it.
  typedef struct packed {
    logic [BUFP_W-1:0]   buf_idx;
    logic [FIELDP_W-1:0] field_idx;
  } field_addr_t;

  // Which stream was granted the shared port most recently.
  typedef enum logic {
    RR_LOADER_LAST  = 1'b0,
    RR_DRAINER_LAST = 1'b1
  } rr_last_e;

endpackage

// File: rtl/pat_buf_mem.sv
// Field memory for the pattern buffers: one read-only port and one shared
// read/write port, both with registered read data.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset (read regs only)
//   a_addr, a_rdata  read-only port, data valid one cycle after the address
//   b_addr           shared port address
//   b_we, b_wdata    shared port write strobe and data
//   b_re, b_rdata    shared port read strobe; b_rdata updates only on b_re
//                    and otherwise holds its last value
//
// A write on port B and a read on port A to the same address in one cycle
// returns the previous contents on port A. The array itself is not reset.
module pat_buf_mem
  import pat_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = BUF_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] a_addr,
  output logic [DW-1:0] a_rdata,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [DW-1:0] b_wdata,
  input  logic          b_re,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Storage array; no reset so it maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (b_we) begin
      mem[b_addr] <= b_wdata;
    end
  end

  // Port A reads every cycle; non-blocking update gives old-data behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= '0;
    end else begin
      a_rdata <= mem[a_addr];
    end
  end

  // Port B read register holds between reads, so it doubles as the output
  // data register of the drain stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_rdata <= '0;
    end else if (b_re) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/pat_buf_sched.sv
// Pattern-buffer scheduler: moves each buffer of a ring through
// load -> core processing -> drain.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_data/in_valid         loader stream; in_ready = field accepted
//   out_data/out_valid       drained fields (registered); out_ready = taken
//   bufp, buf_avail          buffer owned by the core and whether it is filled
//   proc_done                core releases bufp (1-cycle pulse)
//   fieldp, field_rdata      core read index and registered read data
//   fieldwp/field_we/field_wdata  core write index, strobe and data
//   err_done                 sticky: proc_done arrived with no buffer owned
module pat_buf_sched
  import pat_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BUF_W-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BUF_W-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BUFP_W-1:0]   bufp,
  output logic                buf_avail,
  input  logic                proc_done,
  input  logic [FIELDP_W-1:0] fieldp,
  input  logic [FIELDP_W-1:0] fieldwp,
  input  logic                field_we,
  input  logic [BUF_W-1:0]    field_wdata,
  output logic [BUF_W-1:0]    field_rdata,
  output logic                err_done
);

  localparam int CNT_W = BUFP_W + 1;

  logic [BUFP_W-1:0]   fill_ptr, proc_ptr, drain_ptr;
  logic [FIELDP_W-1:0] fill_idx, drain_idx;
  logic [CNT_W-1:0]    cnt_full, cnt_done, cnt_free;
  rr_last_e            rr_last;

  logic core_wr, load_req, drain_req, load_gnt, drain_gnt;
  logic fill_last, drain_last, proc_ok;

  field_addr_t a_addr, b_addr;
  logic        b_we;
  logic [BUF_W-1:0] b_wdata;

  // The partially filled buffer is still counted as free.
  assign cnt_free  = CNT_W'(NBUF) - cnt_full - cnt_done;
  assign buf_avail = (cnt_full != '0);
  assign bufp      = proc_ptr;

  assign core_wr   = field_we && buf_avail;
  assign load_req  = in_valid && (cnt_free != '0);
  assign drain_req = (cnt_done != '0) && (!out_valid || out_ready);
  assign proc_ok   = proc_done && buf_avail;

  // Core writes always win the shared port; otherwise the stream that did
  // not win last time gets it when both ask.
  always_comb begin
    load_gnt  = 1'b0;
    drain_gnt = 1'b0;
    if (!core_wr) begin
      if (load_req && drain_req) begin
        if (rr_last == RR_LOADER_LAST) begin
          drain_gnt = 1'b1;
        end else begin
          load_gnt = 1'b1;
        end
      end else begin
        load_gnt  = load_req;
        drain_gnt = drain_req;
      end
    end
  end

  assign in_ready   = load_gnt;
  assign fill_last  = load_gnt && (&fill_idx);
  assign drain_last = drain_gnt && (&drain_idx);

  // Shared port steering: write from core or loader, otherwise drain read.
  always_comb begin
    b_addr  = '{buf_idx: drain_ptr, field_idx: drain_idx};
    b_we    = 1'b0;
    b_wdata = field_wdata;
    if (core_wr) begin
      b_addr = '{buf_idx: proc_ptr, field_idx: fieldwp};
      b_we   = 1'b1;
    end else if (load_gnt) begin
      b_addr  = '{buf_idx: fill_ptr, field_idx: fill_idx};
      b_we    = 1'b1;
      b_wdata = in_data;
    end
  end

  assign a_addr = '{buf_idx: proc_ptr, field_idx: fieldp};

  pat_buf_mem #(.AW(ADDR_W), .DW(BUF_W)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_addr  (a_addr),
    .a_rdata (field_rdata),
    .b_addr  (b_addr),
    .b_we    (b_we),
    .b_wdata (b_wdata),
    .b_re    (drain_gnt),
    .b_rdata (out_data)
  );

  // Ring pointers and field indices; pointers wrap naturally at NBUF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_ptr  <= '0;
      proc_ptr  <= '0;
      drain_ptr <= '0;
      fill_idx  <= '0;
      drain_idx <= '0;
    end else begin
      if (load_gnt) begin
        fill_idx <= fill_idx + FIELDP_W'(1);
      end
      if (fill_last) begin
        fill_ptr <= fill_ptr + BUFP_W'(1);
      end
      if (proc_ok) begin
        proc_ptr <= proc_ptr + BUFP_W'(1);
      end
      if (drain_gnt) begin
        drain_idx <= drain_idx + FIELDP_W'(1);
      end
      if (drain_last) begin
        drain_ptr <= drain_ptr + BUFP_W'(1);
      end
    end
  end

  // Occupancy counters take every coinciding event in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_full <= '0;
      cnt_done <= '0;
    end else begin
      cnt_full <= cnt_full + CNT_W'(fill_last) - CNT_W'(proc_ok);
      cnt_done <= cnt_done + CNT_W'(proc_ok) - CNT_W'(drain_last);
    end
  end

  // Arbiter history, output valid flag and the sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last   <= RR_LOADER_LAST;
      out_valid <= 1'b0;
      err_done  <= 1'b0;
    end else begin
      if (drain_gnt) begin
        rr_last <= RR_DRAINER_LAST;
      end else if (load_gnt) begin
        rr_last <= RR_LOADER_LAST;
      end
      if (drain_gnt) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (proc_done && !buf_avail) begin
        err_done <= 1'b1;
      end
    end
  end

endmodule
